// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Request scheduler and sequencer for a single elevator car. Floor calls
//   arrive on a valid/ready port and are held in a pending bitmap. The next
//   stop is chosen with SCAN: the car keeps sweeping in one direction while
//   calls remain ahead of it, then reverses. The car steps one floor every
//   MOVE_CYCLES clocks, and the door is held open for DOOR_CYCLES clocks at
//   each floor it serves.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   req_valid      in   a floor call is present
//   req_floor      in   requested floor index
//   req_ready      out  high in every cycle out of reset (no back-pressure)
//   req_err        out  one-cycle pulse after an accepted out-of-range call
//   current_floor  out  car position
//   dir_up         out  sweep direction, 1 = up
//   moving         out  car is travelling between floors
//   door_open      out  door is open at current_floor
//   pending        out  outstanding calls, bit i = floor i
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 40,
  parameter int FLOOR_W     = 6,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_ready,
  output logic                  req_err,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MC_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [MC_W-1:0]       MOVE_LAST = MC_W'(MOVE_CYCLES - 1);
  localparam logic [DC_W-1:0]       DOOR_LAST = DC_W'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0  = NUM_FLOORS'(1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0]      FLOOR_LIM = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t                  state_q,     state_d;
  logic [FLOOR_W-1:0]      floor_q,     floor_d;
  logic                    dir_up_q,    dir_up_d;
  logic [NUM_FLOORS-1:0]   pending_q,   pending_d;
  logic [MC_W-1:0]         move_cnt_q,  move_cnt_d;
  logic [DC_W-1:0]         door_cnt_q,  door_cnt_d;
  logic                    req_err_q,   req_err_d;
  logic                    moving_q,    moving_d;
  logic                    door_open_q, door_open_d;

  logic                    accept;
  logic                    in_range;
  logic                    door_hit;
  logic [NUM_FLOORS-1:0]   set_mask;
  logic [NUM_FLOORS-1:0]   pending_set;
  logic [FLOOR_W-1:0]      step_floor;
  logic                    any_above;
  logic                    any_below;

  // True when p holds a call strictly above (up=1) or strictly below (up=0) f.
  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]    f,
                                       input logic                  up);
    logic [NUM_FLOORS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (up ? (i > int'(f)) : (i < int'(f))) mask[i] = 1'b1;
    end
    return |(p & mask);
  endfunction

  // Ready is simply "not in reset": calls are never back-pressured.
  assign req_ready = ~reset;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    floor_d     = floor_q;
    dir_up_d    = dir_up_q;
    move_cnt_d  = move_cnt_q;
    door_cnt_d  = door_cnt_q;
    moving_d    = moving_q;
    door_open_d = door_open_q;

    accept   = req_valid & req_ready;
    in_range = ({1'b0, req_floor} < FLOOR_LIM);
    // A call for the floor whose door is already open only extends the stop.
    door_hit = accept && in_range && (state_q == S_DOOR) && (req_floor == floor_q);
    set_mask = (accept && in_range && !door_hit) ? (ONE_HOT0 << req_floor) : '0;
    pending_set = pending_q | set_mask;
    pending_d   = pending_set;
    req_err_d   = accept & ~in_range;

    any_above = calls_ahead(pending_q, floor_q, 1'b1);
    any_below = calls_ahead(pending_q, floor_q, 1'b0);

    // Next floor in the current sweep direction, clamped to the shaft ends.
    step_floor = floor_q;
    if (dir_up_q && (floor_q != TOP_FLOOR)) begin
      step_floor = floor_q + FLOOR_W'(1);
    end else if (!dir_up_q && (floor_q != '0)) begin
      step_floor = floor_q - FLOOR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q[floor_q]) begin
          state_d     = S_DOOR;
          door_cnt_d  = '0;
          door_open_d = 1'b1;
          pending_d   = pending_set & ~(ONE_HOT0 << floor_q);
        end else if (any_above && (dir_up_q || !any_below)) begin
          state_d    = S_MOVE;
          dir_up_d   = 1'b1;
          move_cnt_d = '0;
          moving_d   = 1'b1;
        end else if (any_below) begin
          state_d    = S_MOVE;
          dir_up_d   = 1'b0;
          move_cnt_d = '0;
          moving_d   = 1'b1;
        end
      end

      S_MOVE: begin
        if (move_cnt_q == MOVE_LAST) begin
          floor_d    = step_floor;
          move_cnt_d = '0;
          // Arrival decisions see calls accepted in this same cycle, so a
          // call for the arrival floor is served on the spot.
          if (pending_set[step_floor]) begin
            state_d     = S_DOOR;
            moving_d    = 1'b0;
            door_open_d = 1'b1;
            door_cnt_d  = '0;
            pending_d   = pending_set & ~(ONE_HOT0 << step_floor);
          end else if (!calls_ahead(pending_set, step_floor, dir_up_q)) begin
            state_d  = S_IDLE;
            moving_d = 1'b0;
          end
        end else begin
          move_cnt_d = move_cnt_q + MC_W'(1);
        end
      end

      S_DOOR: begin
        if (door_hit) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          state_d     = S_IDLE;
          door_open_d = 1'b0;
        end else begin
          door_cnt_d = door_cnt_q + DC_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        moving_d    = 1'b0;
        door_open_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      move_cnt_q  <= '0;
      door_cnt_q  <= '0;
      req_err_q   <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      move_cnt_q  <= move_cnt_d;
      door_cnt_q  <= door_cnt_d;
      req_err_q   <= req_err_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign req_err       = req_err_q;
  assign current_floor = floor_q;
  assign dir_up        = dir_up_q;
  assign moving        = moving_q;
  assign door_open     = door_open_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler
//   Directed bench for elevator_scheduler with default parameters.
//   Stimulus pushes each expected stop (floor, cycle the door opens) into a
//   queue; a negedge monitor pops an entry on every door_open rising edge.
//   Cycle numbers count rising clock edges; an event "at cycle n" is seen at
//   the falling edge that follows rising edge n.
module tb_elevator_scheduler;

  localparam int NF = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [5:0]    req_floor;
  logic          req_ready;
  logic          req_err;
  logic [5:0]    current_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;

  elevator_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .req_ready     (req_ready),
    .req_err       (req_err),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] floor;
    int         when;
  } stop_t;

  stop_t exp_q[$];
  stop_t mon_s;
  logic  prev_door = 1'b0;
  int    max_floor = 0;
  int    overlap   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every door opening must match the next expected stop.
  always @(negedge clk) begin
    if (reset) begin
      prev_door = 1'b0;
    end else begin
      if (door_open && moving) overlap++;
      if (int'(current_floor) > max_floor) max_floor = int'(current_floor);
      if (door_open && !prev_door) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_stop: door opened at floor %0d cycle %0d, none expected",
                   current_floor, cyc);
        end else begin
          mon_s = exp_q.pop_front();
          check("stop_floor", 64'(current_floor), 64'(mon_s.floor));
          check("stop_cycle", 64'(cyc), 64'(mon_s.when));
        end
      end
      prev_door = door_open;
    end
  end

  task automatic expect_stop(input logic [5:0] f, input int when);
    stop_t s;
    s.floor = f;
    s.when  = when;
    exp_q.push_back(s);
  endtask

  // Called at a falling edge; returns at the next falling edge with acc set
  // to the rising edge that accepted the call.
  task automatic call(input logic [5:0] f, output int acc);
    req_valid = 1'b1;
    req_floor = f;
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    if (n < cyc || n - cyc > 5000) begin
      checks++;
      failures++;
      $display("FAIL schedule: asked to wait for cycle %0d at cycle %0d", n, cyc);
    end else begin
      while (cyc < n) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, b, c, d, e0, e1, e2, e3;
    logic [NF-1:0] expb;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_floor = '0;

    // Reset state.
    @(negedge clk);
    check("rst_ready",   64'(req_ready),     64'd0);
    check("rst_floor",   64'(current_floor), 64'd0);
    check("rst_dir",     64'(dir_up),        64'd1);
    check("rst_pending", 64'(pending),       64'd0);
    check("rst_moving",  64'(moving),        64'd0);
    check("rst_door",    64'(door_open),     64'd0);
    check("rst_err",     64'(req_err),       64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Single call 0 -> 5: one floor every 4 cycles, door at +21 for 8 cycles.
    call(6'd5, a);
    expect_stop(6'd5, a + 21);
    check("t1_pending_set", 64'(pending), 64'h20);
    check("t1_no_err",      64'(req_err), 64'd0);
    wait_cyc(a + 1);
    check("t1_moving", 64'(moving), 64'd1);
    check("t1_floor0", 64'(current_floor), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      wait_cyc(a + 4 * k);
      check("t1_floor_before_step", 64'(current_floor), 64'(k - 1));
      wait_cyc(a + 1 + 4 * k);
      check("t1_floor_step", 64'(current_floor), 64'(k));
    end
    check("t1_door_on",      64'(door_open), 64'd1);
    check("t1_stopped",      64'(moving),    64'd0);
    check("t1_pending_clr",  64'(pending),   64'd0);
    wait_cyc(a + 28);
    check("t1_door_last",    64'(door_open), 64'd1);
    wait_cyc(a + 29);
    check("t1_door_closed",  64'(door_open), 64'd0);

    // SCAN: call 10 from 0, then calls 2 and 7 while passing floor 3.
    do_reset();
    call(6'd10, a);
    wait_cyc(a + 13);
    check("t2_at_floor3", 64'(current_floor), 64'd3);
    call(6'd2, a2);
    call(6'd7, a2);
    expect_stop(6'd7,  a + 29);
    expect_stop(6'd10, a + 50);
    expect_stop(6'd2,  a + 91);
    wait_cyc(a + 29);
    check("t2_dir_at7",  64'(dir_up), 64'd1);
    wait_cyc(a + 50);
    check("t2_dir_at10", 64'(dir_up), 64'd1);
    wait_cyc(a + 58);
    check("t2_dir_idle10", 64'(dir_up), 64'd1);
    wait_cyc(a + 59);
    check("t2_dir_flip", 64'(dir_up), 64'd0);
    check("t2_moving_down", 64'(moving), 64'd1);
    wait_cyc(a + 100);
    check("t2_final_floor", 64'(current_floor), 64'd2);

    // Call for the floor whose door is open: not latched, timer restarts.
    do_reset();
    call(6'd20, b);
    expect_stop(6'd20, b + 81);
    wait_cyc(b + 84);
    call(6'd20, a2);
    check("t3_pending_not_set", 64'(pending), 64'd0);
    check("t3_door_held",       64'(door_open), 64'd1);
    wait_cyc(b + 92);
    check("t3_door_extended",   64'(door_open), 64'd1);
    wait_cyc(b + 93);
    check("t3_door_closed",     64'(door_open), 64'd0);
    check("t3_still_idle",      64'(moving),    64'd0);

    // Out-of-range call: one-cycle error pulse, nothing else changes.
    wait_cyc(b + 95);
    call(6'd45, c);
    check("t4_err_pulse", 64'(req_err),       64'd1);
    check("t4_pending",   64'(pending),       64'd0);
    check("t4_floor",     64'(current_floor), 64'd20);
    check("t4_moving",    64'(moving),        64'd0);
    @(negedge clk);
    check("t4_err_clear", 64'(req_err),       64'd0);
    check("t4_still_idle", 64'(moving),       64'd0);

    // Asynchronous reset while moving through floor 12.
    do_reset();
    call(6'd30, d);
    wait_cyc(d + 50);
    check("t5_floor12", 64'(current_floor), 64'd12);
    check("t5_moving",  64'(moving),        64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_floor",   64'(current_floor), 64'd0);
    check("t5_async_pending", 64'(pending),       64'd0);
    check("t5_async_moving",  64'(moving),        64'd0);
    check("t5_async_ready",   64'(req_ready),     64'd0);
    @(negedge clk);
    check("t5_ready_held_low", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("t5_ready_release", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Burst 39,0,39,39: two pending bits, both served, never above 39.
    call(6'd39, e0);
    call(6'd0,  e1);
    call(6'd39, e2);
    call(6'd39, e3);
    expb = '0;
    expb[39] = 1'b1;
    expb[0]  = 1'b1;
    check("t6_pending_burst", 64'(pending), 64'(expb));
    expect_stop(6'd39, e0 + 157);
    expect_stop(6'd0,  e0 + 322);
    wait_cyc(e0 + 160);
    check("t6_pending_after_top", 64'(pending), 64'd1);
    wait_cyc(e0 + 330);
    check("t6_final_floor",   64'(current_floor), 64'd0);
    check("t6_final_pending", 64'(pending),       64'd0);

    check("all_stops_seen",   64'(exp_q.size()), 64'd0);
    check("max_floor",        64'(max_floor),    64'd39);
    check("door_while_moving", 64'(overlap),     64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
